// File: rtl/firewall_drop_filter_pkg.sv
// firewall_drop_filter_pkg: drop mark, input FSM states and ctrl decode shared by the drop filter.
package firewall_drop_filter_pkg;
    localparam logic [7:0] DROP_MARK = 8'h54;

    typedef enum logic [1:0] {
        S_HDR,
        S_BODY,
        S_OVERSIZE
    } state_t;

    function automatic logic is_eop(input logic [7:0] ctrl);
        return ctrl != 8'h00 && ctrl != DROP_MARK;
    endfunction
endpackage

// File: rtl/fwdrop_buffer_ram.sv
// fwdrop_buffer_ram: simple dual-port packet buffer, one sync write port and one sync read port
// with 1-cycle read latency; the read register resets so the output bus starts at zero.
module fwdrop_buffer_ram #(
    parameter int WIDTH      = 72,
    parameter int ADDR_WIDTH = 9
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_wr_en,
    input  logic [ADDR_WIDTH-1:0] i_wr_addr,
    input  logic [WIDTH-1:0]      i_wr_data,
    input  logic                  i_rd_en,
    input  logic [ADDR_WIDTH-1:0] i_rd_addr,
    output logic [WIDTH-1:0]      o_rd_data
);
    logic [WIDTH-1:0] r_mem [2**ADDR_WIDTH];

    always_ff @(posedge clk)
        if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;

    always_ff @(posedge clk)
        if (reset) o_rd_data <= '0;
        else if (i_rd_en) o_rd_data <= r_mem[i_rd_addr];
endmodule

// File: rtl/firewall_drop_filter.sv
// firewall_drop_filter: store-and-forward stage that buffers whole packets and discards any
// packet carrying the drop mark or exceeding buffer capacity; clean packets pass unmodified.
module firewall_drop_filter
    import firewall_drop_filter_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int CTRL_WIDTH = DATA_WIDTH / 8,
    parameter int ADDR_WIDTH = 9
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic [CTRL_WIDTH-1:0] in_ctrl,
    input  logic                  in_wr,
    output logic                  in_rdy,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [CTRL_WIDTH-1:0] out_ctrl,
    output logic                  out_wr,
    input  logic                  out_rdy,
    output logic [31:0]           pkt_pass_cnt,
    output logic [31:0]           pkt_drop_cnt,
    output logic [31:0]           pkt_oversize_cnt
);
    state_t                r_state, w_state_nxt;
    logic                  r_drop_flag, w_drop_nxt;
    logic [ADDR_WIDTH-1:0] r_wr_ptr, r_rd_ptr, r_commit_ptr;
    logic [ADDR_WIDTH-1:0] w_wr_nxt, w_commit_nxt, w_used, w_pkt_start;
    logic                  r_out_wr;
    logic                  w_full, w_acc, w_ovf, w_wr_en, w_rd_en, w_eop, w_mark;
    logic                  w_pass_inc, w_drop_inc, w_ovs_inc;

    // The open packet always begins where the last committed packet ended.
    assign w_pkt_start = r_commit_ptr;
    assign w_used      = r_wr_ptr - r_rd_ptr;
    assign w_full      = w_used == {ADDR_WIDTH{1'b1}};
    assign in_rdy      = r_state == S_OVERSIZE || !w_full || r_commit_ptr == r_rd_ptr;
    assign w_acc       = in_wr && in_rdy;
    assign w_ovf       = w_acc && r_state != S_OVERSIZE && w_full;
    assign w_wr_en     = w_acc && r_state != S_OVERSIZE && !w_full;
    assign w_rd_en     = out_rdy && r_rd_ptr != r_commit_ptr;
    assign w_eop       = is_eop(in_ctrl);
    assign w_mark      = in_ctrl == DROP_MARK;

    always_comb begin
        w_state_nxt  = r_state;
        w_drop_nxt   = r_drop_flag;
        w_wr_nxt     = r_wr_ptr;
        w_commit_nxt = r_commit_ptr;
        w_pass_inc   = 1'b0;
        w_drop_inc   = 1'b0;
        w_ovs_inc    = 1'b0;
        if (w_acc) begin
            if (w_ovf) begin
                w_wr_nxt    = w_pkt_start;
                w_drop_nxt  = 1'b0;
                w_drop_inc  = 1'b1;
                w_ovs_inc   = 1'b1;
                w_state_nxt = (r_state == S_BODY && w_eop) ? S_HDR : S_OVERSIZE;
            end else if (r_state == S_OVERSIZE) begin
                w_state_nxt = w_eop ? S_HDR : S_OVERSIZE;
            end else if (r_state == S_HDR) begin
                w_wr_nxt = r_wr_ptr + 1'b1;
                if (!w_eop) begin
                    w_state_nxt = S_BODY;
                    w_drop_nxt  = w_mark;
                end
            end else if (w_eop) begin
                w_state_nxt = S_HDR;
                w_drop_nxt  = 1'b0;
                if (r_drop_flag) begin
                    w_wr_nxt   = w_pkt_start;
                    w_drop_inc = 1'b1;
                end else begin
                    w_wr_nxt     = r_wr_ptr + 1'b1;
                    w_commit_nxt = w_wr_nxt;
                    w_pass_inc   = 1'b1;
                end
            end else begin
                w_wr_nxt   = r_wr_ptr + 1'b1;
                w_drop_nxt = r_drop_flag || w_mark;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state          <= S_HDR;
            r_drop_flag      <= 1'b0;
            r_wr_ptr         <= '0;
            r_rd_ptr         <= '0;
            r_commit_ptr     <= '0;
            r_out_wr         <= 1'b0;
            pkt_pass_cnt     <= '0;
            pkt_drop_cnt     <= '0;
            pkt_oversize_cnt <= '0;
        end else begin
            r_state          <= w_state_nxt;
            r_drop_flag      <= w_drop_nxt;
            r_wr_ptr         <= w_wr_nxt;
            r_commit_ptr     <= w_commit_nxt;
            r_rd_ptr         <= w_rd_en ? r_rd_ptr + 1'b1 : r_rd_ptr;
            r_out_wr         <= w_rd_en;
            pkt_pass_cnt     <= pkt_pass_cnt + {31'd0, w_pass_inc};
            pkt_drop_cnt     <= pkt_drop_cnt + {31'd0, w_drop_inc};
            pkt_oversize_cnt <= pkt_oversize_cnt + {31'd0, w_ovs_inc};
        end
    end

    assign out_wr = r_out_wr;

    fwdrop_buffer_ram #(
        .WIDTH     (CTRL_WIDTH + DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_ram (
        .clk      (clk),
        .reset    (reset),
        .i_wr_en  (w_wr_en),
        .i_wr_addr(r_wr_ptr),
        .i_wr_data({in_ctrl, in_data}),
        .i_rd_en  (w_rd_en),
        .i_rd_addr(r_rd_ptr),
        .o_rd_data({out_ctrl, out_data})
    );
endmodule

// File: tb/tb_firewall_drop_filter.sv
// tb_firewall_drop_filter: directed packets into a 512-word and a 16-word instance; a queue of
// expected words per instance is checked against every out_wr beat.
module tb_firewall_drop_filter;
    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] b_in_data, s_in_data, b_out_data, s_out_data;
    logic [7:0]  b_in_ctrl, s_in_ctrl, b_out_ctrl, s_out_ctrl;
    logic        b_in_wr, s_in_wr, b_in_rdy, s_in_rdy, b_out_wr, s_out_wr, b_out_rdy, s_out_rdy;
    logic [31:0] b_pass, b_drop, b_ovs, s_pass, s_drop, s_ovs;
    int          n_checks = 0;
    int          n_fail = 0;
    int          wid = 0;
    logic [71:0] q_b[$];
    logic [71:0] q_s[$];

    always #5 clk = ~clk;

    firewall_drop_filter #(.ADDR_WIDTH(9)) u_big (
        .clk(clk), .reset(reset), .in_data(b_in_data), .in_ctrl(b_in_ctrl), .in_wr(b_in_wr),
        .in_rdy(b_in_rdy), .out_data(b_out_data), .out_ctrl(b_out_ctrl), .out_wr(b_out_wr),
        .out_rdy(b_out_rdy), .pkt_pass_cnt(b_pass), .pkt_drop_cnt(b_drop),
        .pkt_oversize_cnt(b_ovs)
    );

    firewall_drop_filter #(.ADDR_WIDTH(4)) u_small (
        .clk(clk), .reset(reset), .in_data(s_in_data), .in_ctrl(s_in_ctrl), .in_wr(s_in_wr),
        .in_rdy(s_in_rdy), .out_data(s_out_data), .out_ctrl(s_out_ctrl), .out_wr(s_out_wr),
        .out_rdy(s_out_rdy), .pkt_pass_cnt(s_pass), .pkt_drop_cnt(s_drop),
        .pkt_oversize_cnt(s_ovs)
    );

    task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    always @(negedge clk)
        if (!reset) begin
            if (b_out_wr) begin
                if (q_b.size() == 0) check("big_unexpected_word", {b_out_ctrl, b_out_data}, 72'd0);
                else check("big_word", {b_out_ctrl, b_out_data}, q_b.pop_front());
            end
            if (s_out_wr) begin
                if (q_s.size() == 0) check("small_unexpected_word", {s_out_ctrl, s_out_data}, 72'd0);
                else check("small_word", {s_out_ctrl, s_out_data}, q_s.pop_front());
            end
        end

    task automatic put(input int sel, input logic [7:0] c, input logic [63:0] d);
        int n = 0;
        if (sel == 0) begin
            b_in_wr = 1'b1; b_in_ctrl = c; b_in_data = d;
        end else begin
            s_in_wr = 1'b1; s_in_ctrl = c; s_in_data = d;
        end
        while (!(sel == 0 ? b_in_rdy : s_in_rdy) && n < 2000) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 2000) check("in_rdy_timeout", 72'd0, 72'd1);
        @(posedge clk); #1;
    endtask

    task automatic send_pkt(input int sel, input int nbody, input int mark_at, input int mark_n,
                            input bit pass);
        logic [7:0]  c;
        logic [63:0] d;
        for (int i = 0; i < nbody + 2; i++) begin
            c = (i == 0) ? 8'hFF : (i == nbody + 1) ? 8'h01 :
                (i - 1 >= mark_at && i - 1 < mark_at + mark_n) ? 8'h54 : 8'h00;
            d = {32'hC0DE_0000 | 32'(sel), 32'(wid)};
            wid++;
            if (pass && sel == 0) q_b.push_back({c, d});
            if (pass && sel != 0) q_s.push_back({c, d});
            put(sel, c, d);
        end
    endtask

    task automatic wait_drain(input int sel);
        int n = 0;
        while ((sel == 0 ? q_b.size() : q_s.size()) != 0 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("drain_timeout", 72'(sel == 0 ? q_b.size() : q_s.size()), 72'd0);
        repeat (4) @(negedge clk);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        b_in_wr = 1'b0; b_in_ctrl = '0; b_in_data = '0; b_out_rdy = 1'b1;
        s_in_wr = 1'b0; s_in_ctrl = '0; s_in_data = '0; s_out_rdy = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_wr", 72'(b_out_wr), 72'd0);
        check("rst_out_word", {b_out_ctrl, b_out_data}, 72'd0);
        check("rst_pass", 72'(b_pass), 72'd0);
        check("rst_drop", 72'(b_drop), 72'd0);
        check("rst_ovs", 72'(b_ovs), 72'd0);
        check("rst_in_rdy", 72'(s_in_rdy), 72'd1);
        reset = 1'b0;

        // clean 8-word packet, first output exactly two cycles after EOP acceptance
        send_pkt(0, 6, 0, 0, 1'b1);
        b_in_wr = 1'b0;
        @(negedge clk);
        check("lat_t1_idle", 72'(b_out_wr), 72'd0);
        @(negedge clk);
        check("lat_t2_out", 72'(b_out_wr), 72'd1);
        wait_drain(0);
        check("clean_pass", 72'(b_pass), 72'd1);
        check("clean_drop", 72'(b_drop), 72'd0);

        // marked packet: nothing out, write pointer restored
        send_pkt(0, 6, 2, 4, 1'b0);
        b_in_wr = 1'b0;
        repeat (8) @(negedge clk);
        check("mark_wr_ptr", 72'(u_big.r_wr_ptr), 72'd8);
        check("mark_drop", 72'(b_drop), 72'd1);
        check("mark_pass", 72'(b_pass), 72'd1);

        // pass / drop (single mark on first body word) / pass back to back
        send_pkt(0, 6, 0, 0, 1'b1);
        send_pkt(0, 6, 0, 1, 1'b0);
        send_pkt(0, 6, 0, 0, 1'b1);
        b_in_wr = 1'b0;
        wait_drain(0);
        check("b2b_wr_ptr", 72'(u_big.r_wr_ptr), 72'd24);
        check("b2b_pass", 72'(b_pass), 72'd3);
        check("b2b_drop", 72'(b_drop), 72'd2);

        // 16-deep buffer filled by three committed 5-word packets with out_rdy low
        s_out_rdy = 1'b0;
        repeat (3) send_pkt(1, 3, 0, 0, 1'b1);
        s_in_wr = 1'b0;
        check("full_in_rdy", 72'(s_in_rdy), 72'd0);
        repeat (5) @(negedge clk);
        check("full_hold_rdy", 72'(s_in_rdy), 72'd0);
        check("full_no_out", 72'(s_out_wr), 72'd0);
        s_out_rdy = 1'b1;
        wait_drain(1);
        check("drained_in_rdy", 72'(s_in_rdy), 72'd1);
        check("full_pass", 72'(s_pass), 72'd3);

        // 20-word packet into 16-deep buffer is discarded; next packets still forwarded
        send_pkt(1, 18, 0, 0, 1'b0);
        send_pkt(1, 3, 0, 0, 1'b1);
        s_in_wr = 1'b0;
        wait_drain(1);
        check("ovs_cnt", 72'(s_ovs), 72'd1);
        check("ovs_drop", 72'(s_drop), 72'd1);
        check("ovs_after_pass", 72'(s_pass), 72'd4);
        send_pkt(1, 13, 0, 0, 1'b1);
        s_in_wr = 1'b0;
        wait_drain(1);
        check("max_pkt_pass", 72'(s_pass), 72'd5);
        check("max_pkt_ovs", 72'(s_ovs), 72'd1);

        // reset in the middle of a packet body
        put(0, 8'hFF, 64'h1111);
        put(0, 8'h00, 64'h2222);
        put(0, 8'h00, 64'h3333);
        b_in_wr = 1'b0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("mid_rst_out_wr", 72'(b_out_wr), 72'd0);
        check("mid_rst_word", {b_out_ctrl, b_out_data}, 72'd0);
        check("mid_rst_pass", 72'(b_pass), 72'd0);
        check("mid_rst_drop", 72'(b_drop), 72'd0);
        check("mid_rst_small_pass", 72'(s_pass), 72'd0);
        check("mid_rst_wr_ptr", 72'(u_big.r_wr_ptr), 72'd0);
        reset = 1'b0;
        q_b.delete();
        q_s.delete();
        send_pkt(0, 6, 0, 0, 1'b1);
        b_in_wr = 1'b0;
        wait_drain(0);
        check("post_rst_pass", 72'(b_pass), 72'd1);
        check("post_rst_drop", 72'(b_drop), 72'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/firewall_drop_filter.md
# firewall_drop_filter

Store-and-forward stage placed directly downstream of the mini-firewall in the user data path. It buffers each packet whole and discards any packet in which one or more words carry the firewall drop mark in the control byte (ctrl == DROP_MARK). All other packets are forwarded unmodified, so the output-queue stage never sees a marked packet. Pass, drop and oversize counts are exposed as free-running counters.

## Interface
- DATA_WIDTH, 64, data bus width
- CTRL_WIDTH, DATA_WIDTH/8, control bus width
- ADDR_WIDTH, 9, buffer address width; depth = 2^ADDR_WIDTH words
- DROP_MARK, 8'h54, ctrl value marking a word of a rejected packet

- clk  in  1  clock
- reset  in  1  synchronous, active-high
- in_data  in  DATA_WIDTH  input word
- in_ctrl  in  CTRL_WIDTH  input control
- in_wr  in  1  input word valid; honoured only when in_rdy=1 in the same cycle
- in_rdy  out  1  combinational; may accept a word this cycle
- out_data  out  DATA_WIDTH  registered output word
- out_ctrl  out  CTRL_WIDTH  registered output control
- out_wr  out  1  registered; one word per cycle
- out_rdy  in  1  downstream can accept a word
- pkt_pass_cnt  out  32  packets forwarded
- pkt_drop_cnt  out  32  packets discarded (marked or oversize)
- pkt_oversize_cnt  out  32  packets discarded for exceeding capacity

## Operation
- Input FSM, 3 states:
  - S_HDR: ctrl==0 or DROP_MARK → S_BODY, drop_flag = (ctrl==DROP_MARK). Any other ctrl is a module header word; stay in S_HDR.
  - S_BODY: ctrl==0 → stay. ctrl==DROP_MARK → set drop_flag, stay. Any other non-zero ctrl is EOP → end of packet, go to S_HDR.
  - S_OVERSIZE: accept and discard words until EOP, then go to S_HDR.
- Every accepted word in S_HDR/S_BODY is written at wr_ptr; pkt_start records the packet's first address.
- On EOP:
  - drop_flag=1: wr_ptr ← pkt_start; pkt_drop_cnt+1.
  - drop_flag=0: commit_ptr ← wr_ptr+1; pkt_pass_cnt+1.
  - EOP word is itself stored or discarded with the packet.
- Full: used = (wr_ptr − rd_ptr) mod depth == depth−1.
  - Full with commit_ptr ≠ rd_ptr: in_rdy=0.
  - Full with commit_ptr == rd_ptr: in_rdy stays 1. Next accepted word rewinds wr_ptr ← pkt_start; pkt_drop_cnt+1 and pkt_oversize_cnt+1. Go to S_HDR if that word is EOP, else S_OVERSIZE.
  - Maximum forwardable packet: depth−1 words.
- In S_OVERSIZE, in_rdy=1 unconditionally.
- Output: when out_rdy=1 and rd_ptr ≠ commit_ptr, read word at rd_ptr, rd_ptr+1, out_wr=1 next cycle. Otherwise out_wr=0 next cycle.
- Forwarded words are bit-identical to input; DROP_MARK never appears on the output.
- Pointers are ADDR_WIDTH bits and wrap modulo depth. Counters wrap 2^32−1 → 0.
- Reset values: out_wr=0, out_data=0, out_ctrl=0, all counters 0, all pointers 0, state S_HDR, drop_flag 0. A partial packet in flight at reset is lost; upstream restarts at a packet boundary.

## Timing
- Latency: EOP accepted in cycle t → commit visible in t+1 → first word with out_wr=1 in cycle t+2.
- Throughput: 1 word/cycle in each direction, concurrently.
- Simultaneous commit and read: the read sees the pre-commit commit_ptr.
- Simultaneous write and read at full: in_rdy is computed from current-cycle pointers only; no read-bypass credit.
- Counters update the cycle after EOP acceptance.

## Structure
- Shared package: DROP_MARK, state encodings, and an is_eop(ctrl) helper function.
- One sub-module, fwdrop_buffer_ram: simple dual-port RAM, (CTRL_WIDTH+DATA_WIDTH) wide, one synchronous write port and one synchronous read port with 1-cycle read latency.
- FSM, pointers and counters live in the top module.

## Test plan
- Clean packet (header ctrl 0xFF, 6 words ctrl 0, EOP ctrl 0x01) → identical 8 words out starting 2 cycles after EOP; pass_cnt=1.
- Marked packet (header, 2 words ctrl 0, 4 words ctrl 0x54, EOP 0x01) → no out_wr; drop_cnt=1; wr_ptr back to pre-packet value.
- Back-to-back pass/drop/pass → only packets 1 and 3 output, in order and contiguous; pass_cnt=2, drop_cnt=1.
- out_rdy held low with 3 committed packets filling the buffer → in_rdy=0; release out_rdy → all data drains intact and in_rdy reasserts.
- ADDR_WIDTH=4, 20-word clean packet → no output; oversize_cnt=1, drop_cnt=1; following 5-word packet forwarded.
- Reset asserted mid-body → outputs and counters 0; next full packet forwarded correctly.
